// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, ALU and state encodings for the multi-cycle MIPS sequencer
package mips_ctrl_pkg;

  // Instruction opcodes (6-bit; upper two bits are zero for every legal opcode)
  localparam logic [5:0] OP_AND = 6'b000000;
  localparam logic [5:0] OP_OR  = 6'b000001;
  localparam logic [5:0] OP_ADD = 6'b000010;
  localparam logic [5:0] OP_SUB = 6'b000110;
  localparam logic [5:0] OP_SLT = 6'b000111;
  localparam logic [5:0] OP_LW  = 6'b001000;
  localparam logic [5:0] OP_SW  = 6'b001010;
  localparam logic [5:0] OP_BNE = 6'b001110;

  // ALU operation select codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // ALU B operand select codes
  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    WB_MEM   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8
  } state_t;

  // True for the five register-register opcodes
  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // ALU operation used by an R-type opcode in EXEC_R
  function automatic logic [2:0] rtype_alu_op(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_SUB:  code = ALU_SUB;
      OP_SLT:  code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags watchdog expiry
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,    // request outstanding and memory not ready this cycle
  input  logic clear_i,   // request completed, expired, or no request active
  output logic expire_o
);

  // Expiry fires on the wait cycle that brings the count up to TIMEOUT_CYC,
  // so a request never waits more than TIMEOUT_CYC cycles.
  localparam bit ENABLED = (TIMEOUT_CYC != 0);
  localparam int LAST_INT = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(LAST_INT);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  assign expire_o = ENABLED && wait_i && (count_q == LAST);

  // Next count: clear wins, otherwise advance while waiting
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wait_i && ENABLED) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  // Wait-cycle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with shared memory port and watchdog
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_timeout
);

  state_t     state_q;
  state_t     state_d;
  logic       mem_timeout_q;
  logic       expire;
  logic [2:0] alu_op_c;
  logic [5:0] op;

  assign op     = 6'(opcode);
  assign alu_op = ALU_OP_W'(alu_op_c);

  // The memory request depends only on state, which keeps the watchdog
  // path free of combinational loops through the output decode.
  assign mem_req = ~rst & ((state_q == FETCH) || (state_q == MEM_RD) ||
                           (state_q == MEM_WR));

  assign mem_timeout = mem_timeout_q & ~rst;

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (mem_req & ~mem_ready),
    .clear_i  (~mem_req | mem_ready | expire),
    .expire_o (expire)
  );

  // Next-state and per-state datapath controls; all zero while in reset
  always_comb begin
    state_d    = state_q;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_RT;
    alu_op_c   = ALU_AND;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          alu_src_b = ALUB_FOUR;
          alu_op_c  = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end else if (expire) begin
            state_d = FETCH;
          end
        end
        DECODE: begin
          // Branch target is computed here and latched by the datapath
          alu_src_b = ALUB_IMM_SH2;
          alu_op_c  = ALU_ADD;
          if (is_rtype(op)) begin
            state_d = EXEC_R;
          end else if ((op == OP_LW) || (op == OP_SW)) begin
            state_d = MEM_ADDR;
          end else if (op == OP_BNE) begin
            state_d = BRANCH;
          end else begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_RT;
          alu_op_c  = rtype_alu_op(op);
          state_d   = WB_R;
        end
        WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_op_c  = ALU_ADD;
          state_d   = (op == OP_SW) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          iord = 1'b1;
          if (mem_ready) begin
            state_d = WB_MEM;
          end else if (expire) begin
            state_d = FETCH;
          end
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_WR: begin
          iord   = 1'b1;
          mem_we = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end else if (expire) begin
            state_d = FETCH;
          end
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = ALUB_RT;
          alu_op_c   = ALU_SUB;
          pc_src     = 1'b1;
          pc_write   = ~alu_zero;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout_q <= 1'b0;
    end else if (expire) begin
      mem_timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;

  // Watchdog-enabled instance (TIMEOUT_CYC=4)
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_op, mem_timeout;

  // Watchdog-disabled instance (TIMEOUT_CYC=0)
  logic       n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_pc_src, n_alu_src_a;
  logic [1:0] n_alu_src_b;
  logic [2:0] n_alu_op;
  logic       n_reg_write, n_reg_dst, n_mem_to_reg, n_instr_done, n_illegal_op, n_mem_timeout;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .TIMEOUT_CYC(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .TIMEOUT_CYC(0), .TIMEOUT_W(8)) dut_nowd (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .iord(n_iord), .ir_write(n_ir_write),
    .pc_write(n_pc_write), .pc_src(n_pc_src), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .reg_write(n_reg_write),
    .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .instr_done(n_instr_done),
    .illegal_op(n_illegal_op), .mem_timeout(n_mem_timeout)
  );

  // {req,we,iord}_{irw,pcw,pcsrc}_{src_a}_{src_b}_{alu_op}_{rw,rd,m2r}_{done,ill,timeout}
  logic [17:0] outs, n_outs;
  assign outs   = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                   alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op, mem_timeout};
  assign n_outs = {n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_pc_src, n_alu_src_a,
                   n_alu_src_b, n_alu_op, n_reg_write, n_reg_dst, n_mem_to_reg, n_instr_done,
                   n_illegal_op, n_mem_timeout};

  localparam logic [17:0] ZERO    = 18'b000_000_0_00_000_000_000;
  localparam logic [17:0] F_RDY   = 18'b100_110_0_01_010_000_000;
  localparam logic [17:0] F_WAIT  = 18'b100_000_0_01_010_000_000;
  localparam logic [17:0] DEC     = 18'b000_000_0_11_010_000_000;
  localparam logic [17:0] DEC_ILL = 18'b000_000_0_11_010_000_110;
  localparam logic [17:0] EX_AND  = 18'b000_000_1_00_000_000_000;
  localparam logic [17:0] EX_OR   = 18'b000_000_1_00_001_000_000;
  localparam logic [17:0] EX_ADD  = 18'b000_000_1_00_010_000_000;
  localparam logic [17:0] EX_SUB  = 18'b000_000_1_00_011_000_000;
  localparam logic [17:0] EX_SLT  = 18'b000_000_1_00_100_000_000;
  localparam logic [17:0] WBR     = 18'b000_000_0_00_000_110_100;
  localparam logic [17:0] MADDR   = 18'b000_000_1_10_010_000_000;
  localparam logic [17:0] MRD     = 18'b101_000_0_00_000_000_000;
  localparam logic [17:0] WBM     = 18'b000_000_0_00_000_101_100;
  localparam logic [17:0] MWR     = 18'b111_000_0_00_000_000_000;
  localparam logic [17:0] MWR_D   = 18'b111_000_0_00_000_000_100;
  localparam logic [17:0] BR_T    = 18'b000_011_1_00_011_000_100;
  localparam logic [17:0] BR_N    = 18'b000_001_1_00_011_000_100;
  localparam logic [17:0] TO      = 18'b000_000_0_00_000_000_001;

  localparam logic [5:0] O_AND = 6'b000000, O_OR = 6'b000001, O_ADD = 6'b000010;
  localparam logic [5:0] O_SUB = 6'b000110, O_SLT = 6'b000111, O_LW = 6'b001000;
  localparam logic [5:0] O_SW = 6'b001010, O_BNE = 6'b001110, O_ILL = 6'b000011;

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [17:0] exp);
    vec_t v;
    v = '{r: r, op: op, z: z, rdy: rdy, exp: exp};
    vecs.push_back(v);
  endtask

  // Drive one cycle from a negedge, check 1 ns later, then move to the next negedge
  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                      input logic [17:0] exp, input logic chk_nw, input logic [17:0] nw_exp,
                      input string name);
    rst = r; opcode = op; alu_zero = z; mem_ready = rdy;
    #1;
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, outs, exp);
    end
    if (chk_nw) begin
      n_checks++;
      if (n_outs !== nw_exp) begin
        n_fail++;
        $display("FAIL %s (no watchdog): got %b expected %b", name, n_outs, nw_exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b1;

    // Reset held two cycles with mem_ready high
    add(1, O_ADD, 0, 1, ZERO);
    add(1, O_ADD, 0, 1, ZERO);
    // ADD, zero-wait: 4 cycles
    add(0, O_ADD, 0, 1, F_RDY);
    add(0, O_ADD, 0, 1, DEC);
    add(0, O_ADD, 0, 1, EX_ADD);
    add(0, O_ADD, 0, 1, WBR);
    // LW with 3 data wait cycles: 8 cycles
    add(0, O_LW, 0, 1, F_RDY);
    add(0, O_LW, 0, 1, DEC);
    add(0, O_LW, 0, 1, MADDR);
    add(0, O_LW, 0, 0, MRD);
    add(0, O_LW, 0, 0, MRD);
    add(0, O_LW, 0, 0, MRD);
    add(0, O_LW, 0, 1, MRD);
    add(0, O_LW, 0, 1, WBM);
    // BNE taken then not taken
    add(0, O_BNE, 0, 1, F_RDY);
    add(0, O_BNE, 0, 1, DEC);
    add(0, O_BNE, 0, 1, BR_T);
    add(0, O_BNE, 1, 1, F_RDY);
    add(0, O_BNE, 1, 1, DEC);
    add(0, O_BNE, 1, 1, BR_N);
    // Illegal opcode, then FETCH with no register write
    add(0, O_ILL, 0, 1, F_RDY);
    add(0, O_ILL, 0, 1, DEC_ILL);
    // SUB
    add(0, O_SUB, 0, 1, F_RDY);
    add(0, O_SUB, 0, 1, DEC);
    add(0, O_SUB, 0, 1, EX_SUB);
    add(0, O_SUB, 0, 1, WBR);
    // SW zero-wait: 4 cycles
    add(0, O_SW, 0, 1, F_RDY);
    add(0, O_SW, 0, 1, DEC);
    add(0, O_SW, 0, 1, MADDR);
    add(0, O_SW, 0, 1, MWR_D);
    // SLT
    add(0, O_SLT, 0, 1, F_RDY);
    add(0, O_SLT, 0, 1, DEC);
    add(0, O_SLT, 0, 1, EX_SLT);
    add(0, O_SLT, 0, 1, WBR);
    // AND with one fetch wait cycle
    add(0, O_AND, 0, 0, F_WAIT);
    add(0, O_AND, 0, 1, F_RDY);
    add(0, O_AND, 0, 1, DEC);
    add(0, O_AND, 0, 1, EX_AND);
    add(0, O_AND, 0, 1, WBR);
    // Reset mid-instruction, and reset during an outstanding fetch
    add(0, O_OR, 0, 1, F_RDY);
    add(0, O_OR, 0, 1, DEC);
    add(1, O_OR, 0, 1, ZERO);
    add(0, O_OR, 0, 0, F_WAIT);
    add(1, O_OR, 0, 0, ZERO);
    add(0, O_OR, 0, 1, F_RDY);
    add(0, O_OR, 0, 1, DEC);
    add(0, O_OR, 0, 1, EX_OR);
    add(0, O_OR, 0, 1, WBR);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].exp, 1'b1, vecs[i].exp,
           $sformatf("vec %0d", i));
    end

    // Watchdog: SW with mem_ready held low expires on the 4th wait cycle
    step(0, O_SW, 0, 1, F_RDY, 1, F_RDY, "wd fetch");
    step(0, O_SW, 0, 1, DEC,   1, DEC,   "wd decode");
    step(0, O_SW, 0, 1, MADDR, 1, MADDR, "wd addr");
    step(0, O_SW, 0, 0, MWR,   1, MWR,   "wd wait1");
    step(0, O_SW, 0, 0, MWR,   1, MWR,   "wd wait2");
    step(0, O_SW, 0, 0, MWR,   1, MWR,   "wd wait3");
    step(0, O_SW, 0, 0, MWR,   1, MWR,   "wd expire cycle");
    // Watchdog instance back in FETCH with sticky flag; disabled one still waiting
    step(0, O_ADD, 0, 1, F_RDY | TO, 1, MWR_D, "wd back to fetch");
    step(0, O_ADD, 0, 1, DEC | TO,    0, ZERO, "wd sticky decode");
    step(0, O_ADD, 0, 1, EX_ADD | TO, 0, ZERO, "wd sticky exec");
    step(0, O_ADD, 0, 1, WBR | TO,    0, ZERO, "wd sticky wb");
    step(0, O_ADD, 0, 0, F_WAIT | TO, 0, ZERO, "wd sticky fetch wait");
    // Only reset clears the flag
    step(1, O_ADD, 0, 1, ZERO,  1, ZERO,  "wd reset");
    step(0, O_ADD, 0, 1, F_RDY, 1, F_RDY, "wd cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past 100000 time units");
    $fatal(1);
  end

endmodule
